// File: rtl/prog_freq_div_pkg.sv
// Shared types for the programmable frequency divider: output modes, FSM states,
// and a helper that converts a reload value into its division ratio.
package freq_div_pkg;

  typedef enum logic [1:0] {
    PULSE   = 2'b00,
    SQUARE  = 2'b01,
    ONESHOT = 2'b10
  } fd_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } fd_state_e;

  // N = 2^width - reload; a reload of 0 gives the full 2^width period.
  function automatic int unsigned calc_div_ratio(input int unsigned width,
                                                 input int unsigned reload);
    int unsigned full;
    full = 32'd1 << width;
    return full - reload;
  endfunction

endpackage

// File: rtl/prog_freq_div_reload_counter.sv
// Up-counter that loads a start value and saturates at all-ones; the caller
// decides whether terminal count reloads or holds.
module reload_counter #(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             inc,
  output logic             at_max
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (inc && !at_max) begin
      cnt_q <= cnt_q + ONE;
    end
  end

  assign at_max = &cnt_q;

endmodule

// File: rtl/prog_freq_div.sv
// Programmable divider: reload counter plus a small FSM that turns terminal
// counts into pulses, a 50% square wave, or a single one-shot event.
module prog_freq_div
  import freq_div_pkg::*;
#(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             ld,
  input  logic [WIDTH-1:0] reload_in,
  input  logic [1:0]       mode,
  input  logic             start,
  output logic             tc,
  output logic             wave_out,
  output logic             done,
  output logic             busy
);

  logic [WIDTH-1:0] reload_q;
  logic [1:0]       mode_q;
  fd_state_e        state_q;
  logic             wave_q;

  logic             w_at_max;
  logic             w_tc;
  logic             w_is_square;
  logic             w_is_oneshot;
  logic             w_retrigger;
  logic             w_cnt_load;
  logic [WIDTH-1:0] w_cnt_load_val;
  logic             w_cnt_inc;

  // Reserved mode 2'b11 falls through to pulse behaviour.
  assign w_is_square  = (mode_q == SQUARE);
  assign w_is_oneshot = (mode_q == ONESHOT);

  assign w_tc        = (state_q == RUN) && en && w_at_max && !ld;
  assign w_retrigger = (state_q == DONE) && start && w_is_oneshot;

  // A one-shot terminal count leaves the counter parked at all-ones.
  assign w_cnt_load     = ld || (w_tc && !w_is_oneshot) || w_retrigger;
  assign w_cnt_load_val = ld ? reload_in : reload_q;
  assign w_cnt_inc      = (state_q == RUN) && en;

  reload_counter #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (w_cnt_load),
    .load_val (w_cnt_load_val),
    .inc      (w_cnt_inc),
    .at_max   (w_at_max)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reload_q <= '0;
      mode_q   <= PULSE;
      state_q  <= IDLE;
      wave_q   <= 1'b0;
    end else if (ld) begin
      reload_q <= reload_in;
      mode_q   <= mode;
      wave_q   <= 1'b0;
      state_q  <= RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (w_tc) begin
            if (w_is_oneshot) begin
              state_q <= DONE;
            end else if (w_is_square) begin
              wave_q <= ~wave_q;
            end
          end
        end
        DONE: begin
          if (w_retrigger) begin
            state_q <= RUN;
          end
        end
        default: begin
          state_q <= state_q;
        end
      endcase
    end
  end

  assign tc       = w_tc;
  assign wave_out = wave_q;
  assign done     = (state_q == DONE);
  assign busy     = (state_q == RUN);

endmodule
